sb_config_loader: RTL

Configuration writer for the switch box: accepts a word-serial configuration stream over a valid/ready handshake, assembles it into a shadow register and commits the full configuration vector atomically to the switch box `config_in` bus. Sits between the tile configuration controller and one switch box instance; the switch box only ever sees a complete, committed configuration.

---
 rtl/sb_config_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sb_config_loader.sv
// ---------------------------------------------------------------------------
// sb_config_loader
//
// Configuration writer for one switch box. Words arrive over a valid/ready
// stream, are assembled into a shadow register and the whole vector is
// committed to config_out in a single edge, so the switch box never sees a
// partially written configuration.
//
// Build option:
//   SB_CONFIG_PARITY_EN - adds the word_parity input (even parity over
//                         word_in). A word with bad parity aborts the load
//                         into the ERROR state and raises the sticky error
//                         flag. Without the macro the ERROR state does not
//                         exist and error is constant 0.
//
// Parameters:
//   CONFIG_WIDTH  width of the committed configuration vector
//   WORD_WIDTH    width of one stream word
//
// Ports:
//   clock         single clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle request to begin / restart a load
//   word_in       stream data word
//   word_valid    word_in is valid
//   word_parity   even parity of word_in (parity build only)
//   word_ready    loader accepts a word this cycle (combinational)
//   config_out    committed configuration to switch box config_in
//   config_valid  config_out holds a completed load
//   busy          load in progress
//   done          one-cycle pulse after commit
//   error         sticky parity error (0 in the default build)
// ---------------------------------------------------------------------------
module sb_config_loader #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
`ifdef SB_CONFIG_PARITY_EN
  input  logic                    word_parity,
`endif
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1
`ifdef SB_CONFIG_PARITY_EN
    ,
    ST_ERROR = 2'd2
`endif
  } state_t;

`ifdef SB_CONFIG_PARITY_EN
  // True when the word plus its parity bit has an even number of ones.
  function automatic logic parity_ok(input logic [WORD_WIDTH-1:0] w, input logic p);
    return ~(^{w, p});
  endfunction
`endif

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [SHADOW_W-1:0]     shadow_r;
  logic [SHADOW_W-1:0]     merged_s;
  logic [CONFIG_WIDTH-1:0] config_out_r;
  logic                    config_valid_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    word_ready_s;
  logic                    hs_s;
  logic                    par_bad_s;
  logic                    commit_s;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start always wins over a word in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
`ifdef SB_CONFIG_PARITY_EN
        end else if (par_bad_s) begin
          state_nxt_s = ST_ERROR;
`endif
        end else if (commit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
`ifdef SB_CONFIG_PARITY_EN
      ST_ERROR: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output / control decode: ready, handshake, parity check, commit detect.
  always_comb begin
    word_ready_s = 1'b0;
    hs_s         = 1'b0;
    par_bad_s    = 1'b0;
    commit_s     = 1'b0;
    if (state_r == ST_LOAD) begin
      word_ready_s = ~start;
    end else begin
      word_ready_s = 1'b0;
    end
    hs_s = word_valid & word_ready_s;
`ifdef SB_CONFIG_PARITY_EN
    par_bad_s = hs_s & ~parity_ok(word_in, word_parity);
`else
    par_bad_s = 1'b0;
`endif
    commit_s = hs_s & ~par_bad_s & (cnt_r == LAST_IDX);
  end

  // Shadow with the current word dropped into its slot; constant slices keep
  // the insert a plain mux per word position.
  always_comb begin
    merged_s = shadow_r;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (cnt_r == CNT_W'(k)) begin
        merged_s[k*WORD_WIDTH +: WORD_WIDTH] = word_in;
      end else begin
        merged_s[k*WORD_WIDTH +: WORD_WIDTH] = shadow_r[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Datapath and registered outputs. config_out only moves on commit; bits of
  // the last word above CONFIG_WIDTH are dropped by the slice.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r          <= {CNT_W{1'b0}};
      shadow_r       <= {SHADOW_W{1'b0}};
      config_out_r   <= {CONFIG_WIDTH{1'b0}};
      config_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s == ST_LOAD);
      if (start) begin
        // error is already 0 while loading, so clearing on every start is safe
        cnt_r    <= {CNT_W{1'b0}};
        shadow_r <= {SHADOW_W{1'b0}};
        error_r  <= 1'b0;
      end else if (par_bad_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        shadow_r <= {SHADOW_W{1'b0}};
        error_r  <= 1'b1;
      end else if (commit_s) begin
        config_out_r   <= merged_s[CONFIG_WIDTH-1:0];
        config_valid_r <= 1'b1;
        done_r         <= 1'b1;
        cnt_r          <= {CNT_W{1'b0}};
        shadow_r       <= {SHADOW_W{1'b0}};
      end else if (hs_s) begin
        shadow_r <= merged_s;
        cnt_r    <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r    <= cnt_r;
        shadow_r <= shadow_r;
      end
    end
  end

  assign word_ready   = word_ready_s;
  assign config_out   = config_out_r;
  assign config_valid = config_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
`ifdef SB_CONFIG_PARITY_EN
  assign error        = error_r;
`else
  // error_r never sets without the parity check; the port is a constant 0
  assign error        = 1'b0 & error_r;
`endif

endmodule
